// File: rtl/cmos_nvram_bridge.sv
// cmos_nvram_bridge: 1K x 4 Williams CMOS RAM shared by the CPU and the HPS ioctl save/load path.
// Define NVRAM_AUTOSAVE_EN to enable dirty tracking and the SAVE_DELAY automatic save request.
module cmos_nvram_bridge #(
    parameter logic [7:0]  NV_INDEX   = 8'd4,
    parameter int unsigned RAM_AW     = 10,
    parameter logic [23:0] SAVE_DELAY = 24'd6_000_000
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [RAM_AW-1:0] cpu_addr,
    input  logic              cpu_we,
    input  logic [3:0]        cpu_din,
    output logic [3:0]        cpu_dout,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic [16:0]       ioctl_addr,
    input  logic              ioctl_wr,
    input  logic              ioctl_rd,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              ioctl_upload_req,
    input  logic              save_req,
    output logic              nv_busy
);
    localparam int unsigned DEPTH = 1 << RAM_AW;

    typedef enum logic [2:0] {
        IDLE,
`ifdef NVRAM_AUTOSAVE_EN
        DIRTY,
`endif
        REQ,
        UPLOAD,
        DOWNLOAD
    } state_t;

    state_t            state;
    logic [3:0]        ram [DEPTH];
    logic              save_q;
    logic [RAM_AW-1:0] rd_addr;
    logic              rd_oob;
    logic [1:0]        rd_stage;
    logic [3:0]        b_q;

    logic match_c, in_range_c, dl_wr_c, rd_go_c, save_rise_c, busy_drop_c;
    logic unused_c;

    assign match_c     = (ioctl_index == NV_INDEX);
    assign in_range_c  = (ioctl_addr[16:RAM_AW] == '0);
    // CPU wins a same-address collision, so the download write is dropped there
    assign dl_wr_c     = ioctl_download && match_c && ioctl_wr && in_range_c &&
                         !(cpu_we && (cpu_addr == ioctl_addr[RAM_AW-1:0]));
    assign rd_go_c     = ioctl_upload && match_c && ioctl_rd && !ioctl_wait;
    assign save_rise_c = save_req && !save_q;
    assign busy_drop_c = ((state == UPLOAD) && !ioctl_upload) ||
                         ((state == DOWNLOAD) && !ioctl_download);
    assign unused_c    = ^ioctl_dout[7:4];

`ifdef NVRAM_AUTOSAVE_EN
    logic        dirty;
    logic [23:0] cnt;
    logic        cpu_wr_q;
    logic [3:0]  cpu_din_q;
    logic        cpu_diff_c;

    // cpu_dout holds the nibble read in the write cycle, i.e. the value before the write
    assign cpu_diff_c = cpu_wr_q && (cpu_dout != cpu_din_q);
`endif

    always_ff @(posedge clk_sys) begin : ram_write
        if (cpu_we)  ram[cpu_addr] <= cpu_din;
        if (dl_wr_c) ram[ioctl_addr[RAM_AW-1:0]] <= ioctl_dout[3:0];
    end

    always_ff @(posedge clk_sys) begin : port_a_read
        if (reset) cpu_dout <= 4'h0;
        else       cpu_dout <= ram[cpu_addr];
    end

    // Upload handshake: latch address, read port B, then present the byte and release wait
    always_ff @(posedge clk_sys) begin : port_b_read
        if (reset) begin
            rd_stage   <= 2'b00;
            rd_addr    <= '0;
            rd_oob     <= 1'b0;
            b_q        <= 4'h0;
            ioctl_wait <= 1'b0;
            ioctl_din  <= 8'hFF;
        end else begin
            rd_stage <= {rd_stage[0], rd_go_c};
            if (rd_go_c) begin
                rd_addr    <= ioctl_addr[RAM_AW-1:0];
                rd_oob     <= !in_range_c;
                ioctl_wait <= 1'b1;
            end
            if (rd_stage[0]) b_q <= ram[rd_addr];
            if (rd_stage[1]) begin
                ioctl_din  <= rd_oob ? 8'hFF : {4'hF, b_q};
                ioctl_wait <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_sys) begin : fsm
        if (reset) begin
            state            <= IDLE;
            ioctl_upload_req <= 1'b0;
            nv_busy          <= 1'b0;
            save_q           <= 1'b0;
`ifdef NVRAM_AUTOSAVE_EN
            dirty            <= 1'b0;
            cnt              <= 24'd0;
            cpu_wr_q         <= 1'b0;
            cpu_din_q        <= 4'h0;
`endif
        end else begin
            ioctl_upload_req <= 1'b0;
            save_q           <= save_req;
`ifdef NVRAM_AUTOSAVE_EN
            cpu_wr_q         <= cpu_we;
            cpu_din_q        <= cpu_din;
`endif
            case (state)
                UPLOAD, DOWNLOAD: begin
`ifdef NVRAM_AUTOSAVE_EN
                    if (cpu_diff_c) dirty <= 1'b1;
`endif
                    if (busy_drop_c) begin
                        nv_busy <= 1'b0;
                        state   <= IDLE;
`ifdef NVRAM_AUTOSAVE_EN
                        cnt <= 24'd0;
                        if (dirty || cpu_diff_c) state <= DIRTY;
`endif
                    end
                end
                REQ: begin
                    state <= IDLE;
`ifdef NVRAM_AUTOSAVE_EN
                    cnt <= 24'd1;
                    if (cpu_diff_c) begin
                        state <= DIRTY;
                        dirty <= 1'b1;
                        cnt   <= 24'd0;
                    end
`endif
                end
                default: begin
                    // IDLE and DIRTY share the same decisions; DIRTY only means a save is pending
                    if (ioctl_download && match_c) begin
                        state   <= DOWNLOAD;
                        nv_busy <= 1'b1;
                    end else if (ioctl_upload && match_c) begin
                        state   <= UPLOAD;
                        nv_busy <= 1'b1;
`ifdef NVRAM_AUTOSAVE_EN
                        dirty   <= 1'b0;
`endif
                    end else if (save_rise_c) begin
                        state            <= REQ;
                        ioctl_upload_req <= 1'b1;
`ifdef NVRAM_AUTOSAVE_EN
                    end else if (cpu_diff_c) begin
                        state <= DIRTY;
                        dirty <= 1'b1;
                        cnt   <= 24'd0;
                    end else if (dirty) begin
                        if (cnt >= SAVE_DELAY - 24'd1) begin
                            state            <= REQ;
                            ioctl_upload_req <= 1'b1;
                        end else if (cnt != '1) begin
                            cnt <= cnt + 24'd1;
                        end
`endif
                    end
                end
            endcase
        end
    end
endmodule

// File: doc/cmos_nvram_bridge.md
Name: cmos_nvram_bridge

Overview:
- Holds the 1K x 4 Williams CMOS (high-score/settings) RAM for the williams2 core.
- Serves HPS ioctl traffic in both directions:
  - download: HPS writes the RAM from the saved file;
  - upload: the core supplies the RAM contents to HPS on ioctl_upload and raises ioctl_upload_req when the contents have changed.
- Sits in emu between hps_io and williams2. The CPU port replaces the core's internal CMOS RAM.

Parameters:
- NV_INDEX, 8'd4: ioctl_index value selecting NVRAM traffic. Any other index is ignored.
- RAM_AW, 10: CMOS address width (1024 nibbles).
- SAVE_DELAY, 24'd6_000_000: idle clk_sys cycles after the last CPU change before an automatic save request (0.5 s at 12 MHz).

Ports:
- clk_sys, in, 1: system clock (12 MHz).
- reset, in, 1: synchronous, active-high.
- cpu_addr, in, RAM_AW: CPU CMOS address.
- cpu_we, in, 1: CPU write strobe, one cycle.
- cpu_din, in, 4: CPU write data.
- cpu_dout, out, 4: CPU read data, registered, one-cycle latency.
- ioctl_download, in, 1: HPS download active.
- ioctl_upload, in, 1: HPS upload active.
- ioctl_index, in, 8: file index.
- ioctl_addr, in, 17: byte address.
- ioctl_wr, in, 1: download byte strobe.
- ioctl_rd, in, 1: upload byte read strobe.
- ioctl_dout, in, 8: download data.
- ioctl_din, out, 8: upload data.
- ioctl_wait, out, 1: stall to HPS.
- ioctl_upload_req, out, 1: one-cycle save request pulse.
- save_req, in, 1: manual save request (OSD), level; the rising edge is used.
- nv_busy, out, 1: high during a matched upload or download.

Behaviour:
- Reset values:
  - cpu_dout=0, ioctl_din=8'hFF, ioctl_wait=0, ioctl_upload_req=0, nv_busy=0.
  - dirty=0, delay counter=0, FSM=IDLE.
  - RAM contents are NOT cleared by reset.
- RAM:
  - True dual-port, 1024x4.
  - Port A is the CPU port: read every cycle, write on cpu_we.
  - Port B is the ioctl port.
- Index match: match = (ioctl_index == NV_INDEX). Unmatched ioctl traffic has no effect and ioctl_wait stays 0.
- FSM states: IDLE, DIRTY, REQ, UPLOAD, DOWNLOAD.
  - IDLE -> DOWNLOAD on ioctl_download&match.
  - IDLE -> UPLOAD on ioctl_upload&match.
  - IDLE -> DIRTY on a CPU write whose cpu_din differs from the stored nibble. The differ check uses a read-before-write register compare, taken the cycle after the write.
  - DIRTY: the counter restarts at 0 on every differing write. When it reaches SAVE_DELAY-1 -> REQ.
  - REQ: ioctl_upload_req=1 for exactly one cycle -> IDLE, with dirty kept set.
  - IDLE with dirty=1: re-issues REQ every SAVE_DELAY cycles until an upload starts.
  - UPLOAD/DOWNLOAD: nv_busy=1. Exit to IDLE when ioctl_upload/ioctl_download drops.
  - Entering UPLOAD clears dirty.
  - A differing CPU write during UPLOAD sets dirty again. After exit the FSM goes to DIRTY, not IDLE.
- Download:
  - ioctl_wr with ioctl_addr < 1024 writes ioctl_dout[3:0] to RAM[ioctl_addr].
  - Addresses >= 1024 are ignored.
  - A download never sets dirty.
- Upload handshake:
  - On ioctl_rd, the block latches ioctl_addr and asserts ioctl_wait in the same cycle.
  - Cycle +1: port B read.
  - Cycle +2: ioctl_din = {4'hF, nibble}, or 8'hFF if addr >= 1024. ioctl_wait drops in that cycle.
  - ioctl_din holds its value until the next ioctl_rd.
  - An ioctl_rd while ioctl_wait=1 is ignored.
- Collision: a same-cycle CPU write and download write to the same address → the CPU write wins, and the RAM holds cpu_din.
- Manual request: a save_req rising edge in IDLE or DIRTY forces REQ on the next cycle regardless of the counter. The edge is ignored while nv_busy=1.
- Reset mid-upload/download: the FSM returns to IDLE, ioctl_wait drops in the same cycle, and the RAM keeps its current contents.
- Counter width: 24 bits; it saturates rather than wrapping.

Optional Feature:
- Macro: NVRAM_AUTOSAVE_EN.
- Defined: dirty tracking and the SAVE_DELAY automatic request operate as described.
- Undefined:
  - The DIRTY state and the counter are removed.
  - ioctl_upload_req pulses only on a save_req rising edge.
  - CPU writes never trigger a request.

Test Plan:
- Reset, then CPU writes 4'hA to address 10'h005 and reads it back → cpu_dout=4'hA one cycle after the read address is applied. ioctl_upload_req stays 0 until SAVE_DELAY cycles (test value 16) after the write, then pulses high for exactly 1 cycle.
- Download with index 4: bytes 8'h37 at addresses 0..3, plus a byte at 17'h400 → RAM[0..3]=4'h7, address 1024 has no effect, dirty=0, and no request pulse follows.
- Upload with index 4: ioctl_rd at addr 2 → ioctl_wait is high for 2 cycles and ioctl_din=8'hF7. ioctl_rd at addr 17'h500 → ioctl_din=8'hFF.
- Download with index 3: writes 8'h55 at address 0 → RAM unchanged, ioctl_wait stays 0, nv_busy stays 0.
- Same-cycle CPU write 4'h1 and download write 8'h02 to address 9 → RAM[9]=4'h1.
- Reset asserted mid-upload (ioctl_wait=1) → ioctl_wait=0 and FSM=IDLE on the next edge. Build without NVRAM_AUTOSAVE_EN: a CPU write produces no pulse; a save_req rise produces exactly 1 pulse.
